// File: rtl/celda_serial_ctrl_if.sv
// Handshake and operand bundle between top-level control and celda_serial_ctrl.
// CELDA_CASCADE_EN adds the p_in cascade input.
interface celda_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned IW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef CELDA_CASCADE_EN
    logic             p_in;
`endif
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [IW-1:0]    bit_idx;
    logic             p_mid;

    modport master (
`ifdef CELDA_CASCADE_EN
        output p_in,
`endif
        output start, a, b,
        input  busy, done, gt, eq, lt, bit_idx, p_mid
    );

    modport slave (
`ifdef CELDA_CASCADE_EN
        input  p_in,
`endif
        input  start, a, b,
        output busy, done, gt, eq, lt, bit_idx, p_mid
    );
endinterface

// File: rtl/celda_serial_ctrl.sv
// Bit-serial magnitude comparator sequencer: one comparison cell walks the
// operand pair LSB to MSB, carrying the "A>B so far" term in a register.
// Optional macro CELDA_CASCADE_EN: seeds the propagate term from io_bus.p_in
// so several controllers can be chained, lower significance first.
module celda_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    celda_serial_ctrl_if.slave io_bus
);
    localparam int unsigned IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_p;
    logic             r_eqacc;
    logic [IW-1:0]    r_idx;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic             w_ai;
    logic             w_bi;
    logic             w_bit_eq;
    logic             w_p_next;
    logic             w_eqacc_next;
    logic             w_eq_final;
    logic             w_last;
    logic             w_p_init;
    logic             w_accept;

`ifdef CELDA_CASCADE_EN
    logic             r_p_init;
    assign w_p_init   = io_bus.p_in;
    // A propagated "greater" from below means the full values differ.
    assign w_eq_final = w_eqacc_next & ~r_p_init;
`else
    assign w_p_init   = 1'b0;
    assign w_eq_final = w_eqacc_next;
`endif

    // The single comparison cell, fed by the bit currently selected.
    assign w_ai         = r_a[r_idx];
    assign w_bi         = r_b[r_idx];
    assign w_bit_eq     = ~(w_ai ^ w_bi);
    assign w_p_next     = (w_ai & ~w_bi) | (w_bit_eq & r_p);
    assign w_eqacc_next = r_eqacc & w_bit_eq;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_accept     = (r_state == S_IDLE) && io_bus.start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE waits for start, RUN walks all bits, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)       w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, cell state and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_eqacc <= 1'b0;
            r_idx   <= '0;
`ifdef CELDA_CASCADE_EN
            r_p_init <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_p     <= w_p_init;
            r_eqacc <= 1'b1;
            r_idx   <= '0;
`ifdef CELDA_CASCADE_EN
            r_p_init <= w_p_init;
`endif
        end else if (r_state == S_RUN) begin
            r_p     <= w_p_next;
            r_eqacc <= w_eqacc_next;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Results are captured on the last RUN edge so they are valid in DONE
    // and held untouched through any following RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt <= 1'b0;
            r_eq <= 1'b0;
            r_lt <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_gt <= w_p_next;
            r_eq <= w_eq_final;
            r_lt <= ~w_p_next & ~w_eq_final;
        end
    end

    // Outputs decoded from state; bit_idx and p_mid are forced low outside RUN.
    always_comb begin
        io_bus.busy    = (r_state != S_IDLE);
        io_bus.done    = (r_state == S_DONE);
        io_bus.bit_idx = (r_state == S_RUN) ? r_idx : '0;
        io_bus.p_mid   = (r_state == S_RUN) ? w_p_next : 1'b0;
        io_bus.gt      = r_gt;
        io_bus.eq      = r_eq;
        io_bus.lt      = r_lt;
    end

    // Exactly one result flag is set whenever done is signalled.
    a_onehot_result: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_DONE) |-> $onehot({r_gt, r_eq, r_lt}));

    // The bit index never runs past the operand.
    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_idx <= LAST_IDX);

endmodule

// File: doc/celda_serial_ctrl.md
# celda_serial_ctrl

Sequencer that time-shares a single comparison cell across a WIDTH-bit operand pair, processing one bit per clock from LSB to MSB (right to left). It replaces a WIDTH-long structural chain of typical cells with one cell plus a propagation register. It sits between the operand registers and the result display logic of the comparator datapath, with a start/busy/done handshake toward the top-level control.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- p_in  input  1  cascade propagate-in, meaning "lower stage says A>B". Present only with CELDA_CASCADE_EN.
- busy  output  1  high while in RUN or DONE.
- done  output  1  single-cycle pulse when the results become valid.
- gt  output  1  registered result A>B.
- eq  output  1  registered result A==B.
- lt  output  1  registered result A<B.
- bit_idx  output  $clog2(WIDTH)  index of the bit being processed in RUN; 0 otherwise.
- p_mid  output  1  combinational cell output for the current bit; meaningful only in RUN.

## Operation
- The design uses one cell instance, evaluated once per RUN cycle:
  - p_next = (a_i & ~b_i) | (~(a_i ^ b_i) & p)
  - eqacc_next = eqacc & ~(a_i ^ b_i)
- State registers: state, a_q, b_q, p, eqacc, idx, gt, eq, lt.
- FSM states:
  - IDLE: when start=1, latch a_q=a and b_q=b. Set p=p_init, eqacc=1, idx=0, then go to RUN. When start=0, stay in IDLE.
  - RUN: update p and eqacc from bit idx; p_mid = p_next. If idx==WIDTH-1, go to DONE; otherwise idx+=1.
  - DONE: register the results and assert done for exactly one cycle. Always return to IDLE.
- Results captured on entry to DONE:
  - gt = p_final
  - eq = eqacc_final & ~p_init
  - lt = ~gt & ~eq
  - Exactly one of gt/eq/lt is high after the first completion.
- gt/eq/lt hold their values until the next DONE. They do not change during a new RUN.
- start in RUN or DONE is ignored, with no queuing. Operand inputs are don't-care outside the accept cycle.
- Reset (asynchronous, any state): state=IDLE; busy, done, gt, eq, lt, bit_idx, p, eqacc, idx all 0. An in-flight comparison is discarded with no done pulse.
- p_mid drives 0 outside RUN.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1..WIDTH: RUN, with bit_idx = 0..WIDTH-1 respectively.
- Cycle WIDTH+1: DONE. done=1 and busy=1, and gt/eq/lt are valid from this cycle.
- Cycle WIDTH+2: IDLE, busy=0. The earliest next accepted start is in this cycle.
- Total: WIDTH+2 cycles per comparison, start to start.
- bit_idx wraps only by leaving RUN; it never exceeds WIDTH-1.

## Configuration
- CELDA_CASCADE_EN defined:
  - The p_in port exists and p_init = p_in, sampled on the accept cycle.
  - Cascading allows multiple controllers to be chained, lower significance first.
- CELDA_CASCADE_EN undefined:
  - The p_in port is absent and p_init = 0.
  - eq reduces to eqacc_final.

## Test plan
- Reset: drive rst_n=0 mid-RUN (A=8'hF0, B=8'h0F, at cycle 4). Required: all outputs 0 immediately, state IDLE, no done pulse; after release, busy=0.
- Greater: A=8'h81, B=8'h80, start for 1 cycle. Required: busy for 9 cycles; done pulse at cycle 9; gt=1, eq=0, lt=0; bit_idx steps 0..7 during RUN; p_mid=1 at idx 0.
- Less: A=8'h7F, B=8'h80. Required: lt=1 at cycle 9; p_mid=1 for idx 0..6 and 0 at idx 7.
- Equal plus ignored start: A=B=8'h5A, with start re-asserted at cycles 3 and 9. Required: eq=1; exactly one done; the next comparison is accepted only at cycle 10.
- Back-to-back with hold: A=3, B=5, then A=5, B=3, with start at cycles 0 and 10. Required: lt=1 is held through cycles 9..18, and gt=1 from cycle 19.
- With CELDA_CASCADE_EN: A=B=8'h33, p_in=1. Required: gt=1, eq=0, lt=0. With p_in=0: eq=1.
